button_arbiter: RTL and testbench
=================================

BUTTON_ARBITER -- requirements
Module: button_arbiter

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 500000 (10 ms at 50 MHz), number of stable cycles required to accept a press or a release; legal range 2..2^24.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 async_reset  input  1  reset, synchronous and active-high (sampled on rising clk edge).
REQ-004 enable  input  1  when high, new presses may be accepted; driven by the bomb controller in SETUP or COUNTING state.
REQ-005 buttons_raw  input  3  raw push-button levels, active-high, asynchronous to clk.
REQ-006 press_pulse  output  3  one-hot, one-cycle pulse per accepted press; drives the controller's buttons input.
REQ-007 code  output  2  last accepted symbol: 2'b11 for bit 2, 2'b10 for bit 1, 2'b01 for bit 0.
REQ-008 busy  output  1  high whenever the FSM is not IDLE.
REQ-009 collision  output  1  one-cycle pulse when more than one button is high at acceptance.

Function
REQ-010 A two-flop synchronizer SHALL condition buttons_raw; the FSM SHALL only see sync2.
REQ-011 FSM states SHALL be IDLE, DEBOUNCE, HELD and RELEASE.
REQ-012 IDLE: if enable=1 and sync2!=0, latch the winner by fixed priority bit2>bit1>bit0, clear the counter, go to DEBOUNCE; otherwise stay.
REQ-013 Collision SHALL pulse in the cycle after the IDLE->DEBOUNCE edge if sync2 had 2 or 3 bits set on that edge.
REQ-014 DEBOUNCE: counter increments each cycle while the winner bit stays 1; if the winner bit drops or enable drops, go to IDLE with no pulse.
REQ-015 DEBOUNCE: on the edge where counter==DEBOUNCE_CYCLES-1 and the winner is still 1, register press_pulse=winner one-hot, update code, go to HELD.
REQ-016 Latency: with edge 0 the first edge sampling buttons_raw high, press_pulse SHALL be high exactly in the cycle after edge DEBOUNCE_CYCLES+2, for one cycle.
REQ-017 HELD: stay while sync2!=0; when sync2==0, clear the counter and go to RELEASE; enable has no effect.
REQ-018 RELEASE: counter increments while sync2==0; any bit high returns to HELD; counter==DEBOUNCE_CYCLES-1 goes to IDLE.
REQ-019 A button held indefinitely SHALL yield exactly one pulse; buttons other than the winner SHALL be ignored until IDLE is re-entered.
REQ-020 The counter width SHALL be clog2(DEBOUNCE_CYCLES) and it SHALL never wrap: counting stops at DEBOUNCE_CYCLES-1.
REQ-021 press_pulse and collision SHALL be registered outputs, never combinational from buttons_raw.

Reset
REQ-022 async_reset=1 SHALL force IDLE, counter=0, synchronizer flops=0, press_pulse=000, code=00, busy=0, collision=0 on the next edge.
REQ-023 Reset mid-DEBOUNCE SHALL suppress the pending pulse. After reset, a button still held SHALL be re-debounced from zero.

Structure
REQ-024 The state encoding (2 bits) and the symbol codes 11/10/01 SHALL be defined in the shared header bomb_pkg.vh and be used by both this block and bomb_controller.
REQ-025 The debounce counter SHALL be an instance of the existing register sub-module (WIDTH=clog2(DEBOUNCE_CYCLES)) driven with REG_CTRL_CLR, REG_CTRL_INC and REG_CTRL_NOP.
REQ-026 The synchronizer SHALL be inline; no other sub-module.

Verification (DEBOUNCE_CYCLES=4)
REQ-027 Clean press: bit1 held for 20 cycles, then released, enable=1 -> one pulse 010 in the cycle after edge 6, code=10, busy returns low 4 cycles after sync2 clears.
REQ-028 Glitch: bit0 high for 3 cycles only -> no pulse, code unchanged, FSM back in IDLE.
REQ-029 Simultaneous: bits 2 and 0 rise on the same edge -> pulse 100, code=11, collision=1 for one cycle, no later pulse for bit 0 while it stays held.
REQ-030 Release bounce: after acceptance, toggle bit2 0/1 every 2 cycles during release -> no second pulse; IDLE reached only after 4 consecutive low cycles.
REQ-031 Enable/reset: enable=0 with bit2 held -> no pulse; reset asserted on DEBOUNCE cycle 2 -> all outputs 0 next cycle and no pulse.

Source files
------------

// File: rtl/bomb_pkg.sv
// Shared definitions for the bomb datapath: arbiter state encoding, button
// symbol codes and the control encoding of the generic register block.
package bomb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'b00,
    ST_DEBOUNCE = 2'b01,
    ST_HELD     = 2'b10,
    ST_RELEASE  = 2'b11
  } arb_state_t;

  typedef enum logic [1:0] {
    REG_CTRL_NOP = 2'b00,
    REG_CTRL_CLR = 2'b01,
    REG_CTRL_INC = 2'b10
  } reg_ctrl_t;

  // Symbols reported to the controller; 00 means nothing accepted yet.
  localparam logic [1:0] SYM_NONE = 2'b00;
  localparam logic [1:0] SYM_BTN0 = 2'b01;
  localparam logic [1:0] SYM_BTN1 = 2'b10;
  localparam logic [1:0] SYM_BTN2 = 2'b11;

  function automatic logic [2:0] priority_pick(input logic [2:0] levels);
    if (levels[2])      return 3'b100;
    else if (levels[1]) return 3'b010;
    else if (levels[0]) return 3'b001;
    else                return 3'b000;
  endfunction

  function automatic logic [1:0] symbol_of(input logic [2:0] onehot);
    unique case (onehot)
      3'b100:  return SYM_BTN2;
      3'b010:  return SYM_BTN1;
      3'b001:  return SYM_BTN0;
      default: return SYM_NONE;
    endcase
  endfunction

  function automatic logic multi_hot(input logic [2:0] levels);
    return (levels[2] & levels[1]) | (levels[2] & levels[0]) | (levels[1] & levels[0]);
  endfunction

endpackage

// File: rtl/register.sv
// Generic counter/register with clear and increment commands and a
// synchronous active-high reset.
module register
  import bomb_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  reg_ctrl_t        ctrl,
  output logic [WIDTH-1:0] value
);

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (reset) begin
      value <= '0;
    end else begin
      unique case (ctrl)
        REG_CTRL_CLR: value <= '0;
        REG_CTRL_INC: value <= value + WIDTH'(1);
        default:      value <= value;
      endcase
    end
  end

endmodule

// File: rtl/button_arbiter.sv
// Debounces three push buttons, arbitrates simultaneous presses by fixed
// priority (bit2 > bit1 > bit0) and emits one registered pulse per press.
module button_arbiter
  import bomb_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic       clk,
  input  logic       async_reset,
  input  logic       enable,
  input  logic [2:0] buttons_raw,
  output logic [2:0] press_pulse,
  output logic [1:0] code,
  output logic       busy,
  output logic       collision
);

  localparam int                CNT_W    = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [2:0]       sync1;
  logic [2:0]       sync2;
  arb_state_t       state;
  arb_state_t       state_next;
  logic [2:0]       winner;
  reg_ctrl_t        cnt_ctrl;
  logic [CNT_W-1:0] count;
  logic             accept;
  logic             fire;
  logic             winner_hit;
  logic             at_last;
  logic             any_high;

  // Counter only ever increments below CNT_LAST, so it cannot wrap.
  register #(
    .WIDTH(CNT_W)
  ) u_debounce_cnt (
    .clk  (clk),
    .reset(async_reset),
    .ctrl (cnt_ctrl),
    .value(count)
  );

  assign winner_hit = |(sync2 & winner);
  assign any_high   = |sync2;
  assign at_last    = (count == CNT_LAST);
  assign busy       = (state != ST_IDLE);

  // NOTE: every output of this block gets a default before the case, so no
  // path leaves a signal unassigned and no latch is inferred.
  always_comb begin
    state_next = state;
    cnt_ctrl   = REG_CTRL_NOP;
    accept     = 1'b0;
    fire       = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (enable && any_high) begin
          accept     = 1'b1;
          cnt_ctrl   = REG_CTRL_CLR;
          state_next = ST_DEBOUNCE;
        end
      end
      ST_DEBOUNCE: begin
        if (!winner_hit || !enable) begin
          state_next = ST_IDLE;
        end else if (at_last) begin
          fire       = 1'b1;
          state_next = ST_HELD;
        end else begin
          cnt_ctrl = REG_CTRL_INC;
        end
      end
      ST_HELD: begin
        if (!any_high) begin
          cnt_ctrl   = REG_CTRL_CLR;
          state_next = ST_RELEASE;
        end
      end
      ST_RELEASE: begin
        if (any_high) begin
          state_next = ST_HELD;
        end else if (at_last) begin
          state_next = ST_IDLE;
        end else begin
          cnt_ctrl = REG_CTRL_INC;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (async_reset) begin
      sync1       <= '0;
      sync2       <= '0;
      state       <= ST_IDLE;
      winner      <= '0;
      press_pulse <= '0;
      code        <= SYM_NONE;
      collision   <= 1'b0;
    end else begin
      sync1       <= buttons_raw;
      sync2       <= sync1;
      state       <= state_next;
      press_pulse <= fire ? winner : 3'b000;
      collision   <= accept && multi_hot(sync2);
      if (accept) begin
        winner <= priority_pick(sync2);
      end
      if (fire) begin
        code <= symbol_of(winner);
      end
    end
  end

endmodule

// File: tb/tb_button_arbiter.sv
// Self-checking bench for button_arbiter with DEBOUNCE_CYCLES=4: a vector
// table plus hand-written multi-cycle sequences, compared through a queue.
module tb_button_arbiter;

  localparam int DEB = 4;

  logic       clk = 1'b0;
  logic       async_reset;
  logic       enable;
  logic [2:0] buttons_raw;
  logic [2:0] press_pulse;
  logic [1:0] code;
  logic       busy;
  logic       collision;

  typedef struct packed {
    logic [2:0] pulse;
    logic [1:0] code;
    logic       busy;
    logic       coll;
  } out_t;

  typedef struct {
    string      tag;
    logic       rst;
    logic       en;
    logic [2:0] btn;
    out_t       exp;
  } vec_t;

  vec_t tbl[$];
  out_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  button_arbiter #(
    .DEBOUNCE_CYCLES(DEB)
  ) dut (
    .clk        (clk),
    .async_reset(async_reset),
    .enable     (enable),
    .buttons_raw(buttons_raw),
    .press_pulse(press_pulse),
    .code       (code),
    .busy       (busy),
    .collision  (collision)
  );

  always #5 clk = ~clk;

  function automatic out_t mk(input logic [2:0] p, input logic [1:0] c,
                              input logic b, input logic col);
    return out_t'({p, c, b, col});
  endfunction

  function automatic void add(input string tag, input logic rst, input logic en,
                              input logic [2:0] btn, input out_t exp);
    vec_t v;
    v.tag = tag;
    v.rst = rst;
    v.en  = en;
    v.btn = btn;
    v.exp = exp;
    tbl.push_back(v);
  endfunction

  task automatic check(input string name, input out_t act, input out_t exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got pulse=%b code=%b busy=%b coll=%b, want pulse=%b code=%b busy=%b coll=%b",
               name, act.pulse, act.code, act.busy, act.coll,
               exp.pulse, exp.code, exp.busy, exp.coll);
    end
  endtask

  // Inputs are driven at a falling edge; the expected outputs refer to the
  // cycle after the next rising edge and are compared at the following fall.
  task automatic step(input string tag, input logic rst, input logic en,
                      input logic [2:0] btn, input out_t exp);
    out_t act;
    out_t want;
    async_reset = rst;
    enable      = en;
    buttons_raw = btn;
    sb.push_back(exp);
    @(negedge clk);
    act  = out_t'({press_pulse, code, busy, collision});
    want = sb.pop_front();
    check(tag, act, want);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time=%0t exceeded limit=100000", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    async_reset = 1'b1;
    enable      = 1'b0;
    buttons_raw = 3'b000;

    for (int i = 0; i < 2; i++) add("reset", 1'b1, 1'b0, 3'b000, mk(3'b000, 2'b00, 1'b0, 1'b0));

    // Clean press of bit1: pulse after edge 6, release takes the FSM back
    // to IDLE after the four RELEASE cycles.
    for (int i = 0; i < 20; i++)
      add($sformatf("clean[%0d]", i), 1'b0, 1'b1, 3'b010,
          mk(i == 6 ? 3'b010 : 3'b000, i >= 6 ? 2'b10 : 2'b00, i >= 2, 1'b0));
    for (int i = 20; i < 28; i++)
      add($sformatf("clean_rel[%0d]", i), 1'b0, 1'b1, 3'b000,
          mk(3'b000, 2'b10, i <= 25, 1'b0));

    // Three-cycle glitch on bit0: enters DEBOUNCE, aborts, no pulse.
    for (int i = 0; i < 9; i++)
      add($sformatf("glitch[%0d]", i), 1'b0, 1'b1, i < 3 ? 3'b001 : 3'b000,
          mk(3'b000, 2'b10, i >= 2 && i <= 4, 1'b0));

    // Bits 2 and 0 together: bit2 wins, collision flagged; bit0 held on
    // alone afterwards must not produce a second pulse.
    for (int i = 0; i < 28; i++)
      add($sformatf("simul[%0d]", i), 1'b0, 1'b1,
          i < 12 ? 3'b101 : (i < 20 ? 3'b001 : 3'b000),
          mk(i == 6 ? 3'b100 : 3'b000, i >= 6 ? 2'b11 : 2'b10,
             i >= 2 && i <= 25, i == 2));

    for (int i = 0; i < tbl.size(); i++)
      step(tbl[i].tag, tbl[i].rst, tbl[i].en, tbl[i].btn, tbl[i].exp);

    // Release bounce: bit2 toggles every two cycles after acceptance.
    for (int k = 0; k < 10; k++)
      step($sformatf("bounce_press[%0d]", k), 1'b0, 1'b1, 3'b100,
           mk(k == 6 ? 3'b100 : 3'b000, 2'b11, k >= 2, 1'b0));
    for (int k = 0; k < 16; k++)
      step($sformatf("bounce_toggle[%0d]", k), 1'b0, 1'b1,
           ((k / 2) % 2 == 0) ? 3'b000 : 3'b100, mk(3'b000, 2'b11, 1'b1, 1'b0));
    for (int k = 0; k < 8; k++)
      step($sformatf("bounce_settle[%0d]", k), 1'b0, 1'b1, 3'b000,
           mk(3'b000, 2'b11, k <= 5, 1'b0));

    // Enable low: a held button is never accepted.
    for (int k = 0; k < 10; k++)
      step($sformatf("enable_low[%0d]", k), 1'b0, 1'b0, 3'b100,
           mk(3'b000, 2'b11, 1'b0, 1'b0));
    for (int k = 0; k < 3; k++)
      step($sformatf("enable_low_rel[%0d]", k), 1'b0, 1'b0, 3'b000,
           mk(3'b000, 2'b11, 1'b0, 1'b0));

    // Reset during the second DEBOUNCE cycle, then re-debounce from zero.
    for (int k = 0; k < 4; k++)
      step($sformatf("rst_deb[%0d]", k), 1'b0, 1'b1, 3'b010,
           mk(3'b000, 2'b11, k >= 2, 1'b0));
    step("rst_hit", 1'b1, 1'b1, 3'b010, mk(3'b000, 2'b00, 1'b0, 1'b0));
    for (int k = 0; k < 10; k++)
      step($sformatf("rst_redeb[%0d]", k), 1'b0, 1'b1, 3'b010,
           mk(k == 6 ? 3'b010 : 3'b000, k >= 6 ? 2'b10 : 2'b00, k >= 2, 1'b0));
    for (int k = 0; k < 8; k++)
      step($sformatf("rst_rel[%0d]", k), 1'b0, 1'b1, 3'b000,
           mk(3'b000, 2'b10, k <= 5, 1'b0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
